// File: rtl/wishbone_fetch_master.sv
// Single-beat Wishbone classic read initiator for instruction fetch, with flush support.
// Optional bus-timeout watchdog enabled by defining WB_FETCH_TIMEOUT_EN.
module wishbone_fetch_master #(
    parameter int ADDR_W      = 10,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              flush_i,
    output logic              ready_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              valid_o,
    output logic              err_o,
    output logic              cyc_o,
    output logic              stb_o,
    output logic              we_o,
    output logic [3:0]        sel_o,
    output logic [ADDR_W-1:0] adr_o,
    output logic [DATA_W-1:0] dat_o,
    input  logic [DATA_W-1:0] dat_i,
    input  logic              ack_i
);

    typedef enum logic [1:0] {IDLE, BUSY, GAP} state_e;

    state_e            state_q, state_d;
    logic              cyc_q, cyc_d;
    logic [ADDR_W-1:0] adr_q, adr_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;
    logic              kill_q, kill_d;
    logic              timeout;

`ifdef WB_FETCH_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
    logic [CNT_W-1:0] cnt_q;

    // Counter sits at zero outside BUSY, so it is always clear on entry.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (state_q != BUSY) begin
            cnt_q <= '0;
        end else if (!ack_i) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign timeout = (state_q == BUSY) && !ack_i && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
`else
    // Without the watchdog a fetch waits for ack forever.
    assign timeout = (TIMEOUT_CYC < 0);
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cyc_q   <= 1'b0;
            adr_q   <= '0;
            rdata_q <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            kill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            adr_q   <= adr_d;
            rdata_q <= rdata_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            kill_q  <= kill_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        adr_d   = adr_q;
        rdata_d = rdata_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        kill_d  = kill_q;
        case (state_q)
            IDLE: begin
                if (req_i) begin
                    adr_d   = addr_i;
                    cyc_d   = 1'b1;
                    kill_d  = flush_i;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (flush_i) begin
                    kill_d = 1'b1;
                end
                if (ack_i) begin
                    cyc_d   = 1'b0;
                    state_d = GAP;
                    // A flush seen now or earlier in the cycle discards the word.
                    if (!kill_q && !flush_i) begin
                        rdata_d = dat_i;
                        valid_d = 1'b1;
                    end
                end else if (timeout) begin
                    cyc_d   = 1'b0;
                    state_d = GAP;
                    err_d   = !kill_q && !flush_i;
                end
            end
            GAP: begin
                kill_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign ready_o = (state_q == IDLE);
    assign rdata_o = rdata_q;
    assign valid_o = valid_q;
    assign err_o   = err_q;
    assign cyc_o   = cyc_q;
    assign stb_o   = cyc_q;
    assign we_o    = 1'b0;
    assign sel_o   = 4'hF;
    assign adr_o   = adr_q;
    assign dat_o   = '0;

endmodule

// File: tb/tb_wishbone_fetch_master.sv
// Directed bench for wishbone_fetch_master: registered-ack ROM slave, expected-data queue, valid_o monitor.
module tb_wishbone_fetch_master;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
`ifdef WB_FETCH_TIMEOUT_EN
    localparam int TO_CYC = 8;
`else
    localparam int TO_CYC = 255;
`endif

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b1;
    logic              req_i = 1'b0;
    logic [ADDR_W-1:0] addr_i = '0;
    logic              flush_i = 1'b0;
    logic              ready_o, valid_o, err_o, cyc_o, stb_o, we_o, ack_i;
    logic [DATA_W-1:0] rdata_o, dat_o, dat_i;
    logic [3:0]        sel_o;
    logic [ADDR_W-1:0] adr_o;

    wishbone_fetch_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYC(TO_CYC)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .addr_i(addr_i), .flush_i(flush_i),
        .ready_o(ready_o), .rdata_o(rdata_o), .valid_o(valid_o), .err_o(err_o),
        .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .sel_o(sel_o), .adr_o(adr_o),
        .dat_o(dat_o), .dat_i(dat_i), .ack_i(ack_i)
    );

    // clock / reset
    always #5 clk_i = ~clk_i;

    // instruction ROM slave with registered ack and programmable extra wait
    int          ack_delay = 0;
    logic        slave_mute = 1'b0;
    logic        spur_ack = 1'b0;
    int          wait_cnt;
    logic        ack_s;
    logic [31:0] dat_s;

    function automatic logic [31:0] rom_word(input logic [ADDR_W-1:0] a);
        if (a == 10'h004) return 32'h00500093;
        return 32'hC0DE0000 | 32'(a);
    endfunction

    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ack_s <= 1'b0; wait_cnt <= 0; dat_s <= '0;
        end else if (cyc_o && stb_o && !ack_s && !slave_mute) begin
            if (wait_cnt >= ack_delay) begin
                ack_s <= 1'b1; dat_s <= rom_word(adr_o); wait_cnt <= 0;
            end else begin
                wait_cnt <= wait_cnt + 1;
            end
        end else begin
            ack_s <= 1'b0;
            if (!cyc_o) wait_cnt <= 0;
        end
    end
    assign ack_i = ack_s | spur_ack;
    assign dat_i = dat_s;

    // scoreboard
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc_cnt = 0;
    int          err_cnt = 0;
    logic        prev_v = 1'b0;
    logic [DATA_W-1:0] exp_q[$];
    int          vcyc_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // monitor: pops the expected queue on every valid_o pulse
    always @(negedge clk_i) begin
        cyc_cnt++;
        if (!rst_i) begin
            if (valid_o) begin
                check("valid_gap", 32'(prev_v), 0);
                check("valid_pending", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) check("rdata", rdata_o, exp_q.pop_front());
                vcyc_q.push_back(cyc_cnt);
            end
            if (err_o) err_cnt++;
            prev_v = valid_o;
        end else begin
            prev_v = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // driver tasks
    task automatic tick();
        @(posedge clk_i); #1;
    endtask

    task automatic wait_ready();
        int k = 0;
        while (!ready_o && k < 50) begin tick(); k++; end
        check("ready_wait", 32'(ready_o), 1);
    endtask

    task automatic issue(input logic [ADDR_W-1:0] a, input logic [31:0] exp, input bit push);
        wait_ready();
        req_i = 1'b1; addr_i = a;
        if (push) exp_q.push_back(exp);
        tick();
        req_i = 1'b0;
    endtask

    task automatic wait_ack();
        int k = 0;
        while (!ack_i && k < 40) begin tick(); k++; end
        check("ack_wait", 32'(ack_i), 1);
    endtask

    initial begin
        int base;
        int e0;
        int cnt;
        int k;

        // reset state
        #22;
        check("rst_cyc", 32'(cyc_o), 0);
        check("rst_stb", 32'(stb_o), 0);
        check("rst_valid", 32'(valid_o), 0);
        check("rst_rdata", rdata_o, 0);
        check("rst_adr", 32'(adr_o), 0);
        check("rst_err", 32'(err_o), 0);
        @(negedge clk_i); rst_i = 1'b0;
        tick();
        check("rst_ready", 32'(ready_o), 1);
        check("static_we_sel", {27'd0, we_o, sel_o}, 32'h0F);
        check("static_dat", dat_o, 0);

        // single fetch, ack one cycle after stb
        issue(10'h004, 32'h00500093, 1);
        check("t1_adr", 32'(adr_o), 32'h004);
        check("t1_stb", 32'(stb_o), 1);
        check("t1_ack_late", 32'(ack_i), 0);
        tick();
        check("t1_ack", 32'(ack_i), 1);
        check("t1_stb_at_ack", 32'(stb_o), 1);
        tick();
        check("t1_valid", 32'(valid_o), 1);
        check("t1_ready_gap", 32'(ready_o), 0);
        check("t1_cyc_gap", 32'(cyc_o), 0);
        tick();
        check("t1_ready_back", 32'(ready_o), 1);
        check("t1_valid_once", 32'(valid_o), 0);

        // req held high across addresses 0,1,2
        base = vcyc_q.size();
        req_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            addr_i = ADDR_W'(i);
            exp_q.push_back(32'hC0DE0000 | 32'(i));
            k = 0;
            while (!ready_o && k < 20) begin tick(); k++; end
            check("t2_stb_low_between", 32'(stb_o), 0);
            tick();
            check("t2_adr", 32'(adr_o), 32'(i));
        end
        req_i = 1'b0;
        wait_ready();
        check("t2_count", 32'(vcyc_q.size() - base), 3);
        if (vcyc_q.size() >= base + 3) begin
            check("t2_spacing01", 32'(vcyc_q[base+1] - vcyc_q[base]), 4);
            check("t2_spacing12", 32'(vcyc_q[base+2] - vcyc_q[base+1]), 4);
        end

        // flush in 2nd BUSY cycle with a slow slave
        ack_delay = 5;
        issue(10'h008, 0, 0);
        tick();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        wait_ack();
        check("t3_cyc_until_ack", 32'(cyc_o), 1);
        tick();
        check("t3_no_valid", 32'(valid_o), 0);
        check("t3_cyc_drop", 32'(cyc_o), 0);
        tick();
        check("t3_rdata_kept", rdata_o, 32'hC0DE0002);
        ack_delay = 0;
        issue(10'h005, 32'hC0DE0005, 1);
        wait_ready();

        // flush in the same cycle as ack
        issue(10'h006, 0, 0);
        tick();
        check("t4_ack", 32'(ack_i), 1);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        check("t4_no_valid", 32'(valid_o), 0);
        tick();
        check("t4_rdata_kept", rdata_o, 32'hC0DE0005);

        // flush while idle is harmless
        wait_ready();
        flush_i = 1'b1;
        tick(); tick();
        flush_i = 1'b0;
        issue(10'h007, 32'hC0DE0007, 1);
        wait_ready();

        // spurious ack in IDLE, then in GAP
        spur_ack = 1'b1;
        tick();
        check("t6_idle_ready", 32'(ready_o), 1);
        check("t6_idle_cyc", 32'(cyc_o), 0);
        tick();
        spur_ack = 1'b0;
        check("t6_idle_valid", 32'(valid_o), 0);
        tick();
        issue(10'h009, 32'hC0DE0009, 1);
        tick();
        tick();
        spur_ack = 1'b1;
        tick();
        spur_ack = 1'b0;
        check("t6_gap_ready", 32'(ready_o), 1);
        check("t6_gap_cyc", 32'(cyc_o), 0);
        tick();
        check("t6_gap_valid", 32'(valid_o), 0);

        // reset in the middle of a bus cycle
        ack_delay = 5;
        issue(10'h003, 0, 0);
        check("t7_stb_before", 32'(stb_o), 1);
        #2 rst_i = 1'b1;
        #1;
        check("t7_cyc_async", 32'(cyc_o), 0);
        check("t7_stb_async", 32'(stb_o), 0);
        @(negedge clk_i); rst_i = 1'b0;
        ack_delay = 0;
        tick();
        check("t7_ready", 32'(ready_o), 1);
        check("t7_valid", 32'(valid_o), 0);

`ifdef WB_FETCH_TIMEOUT_EN
        // slave never acks: watchdog ends the cycle
        slave_mute = 1'b1;
        e0 = err_cnt;
        issue(10'h001, 0, 0);
        cnt = 0;
        while (stb_o && cnt < 40) begin cnt++; tick(); end
        check("t8_busy_cycles", 32'(cnt), 8);
        check("t8_err", 32'(err_o), 1);
        check("t8_valid", 32'(valid_o), 0);
        tick();
        check("t8_ready", 32'(ready_o), 1);
        check("t8_err_once", 32'(err_cnt - e0), 1);
        slave_mute = 1'b0;
`else
        e0 = 0;
        cnt = 0;
        check("err_never", 32'(err_cnt + e0 + cnt), 0);
`endif

        repeat (5) tick();
        check("exp_q_drained", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
